vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Raster timing source that produces the DrawX/DrawY scan coordinates consumed by every sprite/object block (`is_*` hit tests), plus the VGA sync and blank strobes. It sits between the board clock and the color mapper/VGA DAC and is the single authority for the pixel position each cycle. The default timing is 640x480 @ 60 Hz from a 50 MHz `Clk`, with the pixel rate derived by clock enable.

Parameters:
- CLK_DIV, 2: `Clk` cycles per pixel (>=1); the pixel enable fires once per CLK_DIV cycles.
- H_VISIBLE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- pixel_en  out  1  high on the single `Clk` cycle in which the counters advance at the next edge.
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1.
- DrawY  out  10  current vertical count, 0..V_TOTAL-1.
- VGA_HS  out  1  horizontal sync, active low.
- VGA_VS  out  1  vertical sync, active low.
- VGA_BLANK_N  out  1  high when DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- line_start  out  1  one-`Clk` pulse on the first cycle DrawX==0 after a wrap.
- frame_start  out  1  one-`Clk` pulse on the first cycle DrawX==0 and DrawY==0 after a wrap.

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 480+10+2+33 = 525. Both must fit in 10 bits; enforce this with an elaboration-time check.
- Divider `div_cnt` runs 0..CLK_DIV-1 and wraps. pixel_en = (div_cnt == CLK_DIV-1) combinationally. With CLK_DIV=1, pixel_en is constantly high, except that it is 0 during Reset.
- Counter advance on a `Clk` edge with pixel_en=1:
  - `h_cnt` increments.
  - At H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At V_TOTAL-1, `v_cnt` wraps to 0.
  - Without pixel_en, both counters hold.
- DrawX = `h_cnt` and DrawY = `v_cnt`; both are registers.
- VGA_HS, VGA_VS and VGA_BLANK_N are registered, decoded from the next-state counter values. They therefore change on the same edge as DrawX/DrawY, with zero relative skew.
  - VGA_HS=0 iff H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - VGA_VS=0 iff V_VISIBLE+V_FP <= v < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491. The vertical decode ignores h, so VS edges align with the h=0 transition.
- line_start and frame_start are registered and asserted for exactly one `Clk` cycle, on the edge where the counters wrap. They are never asserted on the cycle after reset release.
- Reset, at any point including mid-line or mid-sync:
  - Next edge: div_cnt=0, DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=1, line_start=0, frame_start=0, pixel_en=0 while Reset is high.
  - The first pixel (0,0) after release lasts CLK_DIV cycles counted from release.
- Pixel timing:
  - Every pixel position is held for exactly CLK_DIV `Clk` cycles.
  - A line is H_TOTAL*CLK_DIV = 1600 cycles.
  - A frame is 840000 cycles.
- There are no inputs besides `Clk`/`Reset`, so there are no simultaneous-event cases beyond the h-wrap/v-wrap coincidence at (799,524). That coincidence must produce (0,0), with line_start and frame_start both pulsing.

Decomposition:
- Package `vga_pkg`:
  - default timing localparams (H_*/V_* above, H_TOTAL, V_TOTAL);
  - derived sync start/end constants;
  - a `coord_t` typedef = logic [9:0], shared with all object blocks for DrawX/DrawY.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal and vertical):
  - parameters: VISIBLE, FP, SYNC, BP;
  - inputs: Clk, Reset, advance;
  - outputs: count, wrap (combinational, = advance && count==TOTAL-1), sync_n_next, active_next.
- The top level holds the divider, the output registers and the pulse generation.

Test Plan:
- Reset held 3 cycles, then released -> DrawX=0, DrawY=0, HS=1, VS=1, BLANK_N=1, no pulses; pixel_en first high 1 cycle after release (CLK_DIV=2).
- Run 1600 `Clk` cycles from reset release -> DrawX back at 0, DrawY=1, exactly one line_start pulse, no frame_start.
- Observe one line -> VGA_HS falls on the edge DrawX becomes 656 and rises when DrawX becomes 752 (192 `Clk` low). VGA_BLANK_N falls when DrawX becomes 640 and rises at 0.
- Run a full frame -> VGA_VS low only while DrawY in 490..491 (3200 cycles). frame_start period = 840000 cycles, coincident with a line_start at (0,0).
- Assert Reset for 1 cycle while DrawX=700, DrawY=490 (HS and VS both low) -> next edge DrawX=0, DrawY=0, HS=1, VS=1, no frame_start pulse.
- Elaborate with CLK_DIV=1 -> pixel_en constantly 1 outside reset; line = 800 cycles; frame = 420000 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA raster constants and the scan-coordinate type used by every object block.
package vga_pkg;

   localparam int unsigned COORD_W   = 10;
   localparam int unsigned COORD_MAX = 2 ** COORD_W;

   function automatic int unsigned axis_total(input int unsigned visible,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return visible + fp + sync + bp;
   endfunction

   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FP      = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BP      = 48;
   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FP      = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BP      = 33;

   localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

   // Sync pulse spans [START, END) in the counter's own units.
   localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

   typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap strobe and next-state sync/active decode.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned VISIBLE = H_VISIBLE,
   parameter int unsigned FP      = H_FP,
   parameter int unsigned SYNC    = H_SYNC,
   parameter int unsigned BP      = H_BP
) (
   input  logic   Clk,
   input  logic   Reset,
   input  logic   advance,
   output coord_t count,
   output logic   wrap,
   output logic   sync_n_next,
   output logic   active_next
);

   localparam int unsigned TOTAL      = axis_total(VISIBLE, FP, SYNC, BP);
   localparam int unsigned SYNC_START = VISIBLE + FP;
   localparam int unsigned SYNC_END   = SYNC_START + SYNC;

   if (TOTAL > COORD_MAX) begin : g_total_check
      $error("vga_axis_counter: total %0d does not fit the coordinate width", TOTAL);
   end

   coord_t      count_q;
   coord_t      count_d;
   logic [31:0] count_d_ext;

   assign wrap = advance && (count_q == COORD_W'(TOTAL - 1));

   always_comb begin
      count_d = count_q;
      if (wrap) begin
         count_d = '0;
      end else if (advance) begin
         count_d = count_q + COORD_W'(1);
      end
   end

   // Decode from the next count so registered strobes line up with the count register.
   always_comb begin
      count_d_ext = 32'(count_d);
      sync_n_next = !((count_d_ext >= SYNC_START) && (count_d_ext < SYNC_END));
      active_next = (count_d_ext < VISIBLE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel-rate divider, horizontal/vertical counters and
// registered sync, blank and line/frame start strobes.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int unsigned H_FP      = vga_pkg::H_FP,
   parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
   parameter int unsigned H_BP      = vga_pkg::H_BP,
   parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int unsigned V_FP      = vga_pkg::V_FP,
   parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
   parameter int unsigned V_BP      = vga_pkg::V_BP
) (
   input  logic            Clk,
   input  logic            Reset,
   output logic            pixel_en,
   output vga_pkg::coord_t DrawX,
   output vga_pkg::coord_t DrawY,
   output logic            VGA_HS,
   output logic            VGA_VS,
   output logic            VGA_BLANK_N,
   output logic            line_start,
   output logic            frame_start
);

   localparam int unsigned H_TOTAL = vga_pkg::axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = vga_pkg::axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? 32'($clog2(CLK_DIV)) : 32'd1;

   if (CLK_DIV < 1) begin : g_div_check
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if (H_TOTAL > vga_pkg::COORD_MAX) begin : g_h_total_check
      $error("vga_timing_gen: H_TOTAL %0d exceeds 10 bits", H_TOTAL);
   end
   if (V_TOTAL > vga_pkg::COORD_MAX) begin : g_v_total_check
      $error("vga_timing_gen: V_TOTAL %0d exceeds 10 bits", V_TOTAL);
   end

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             div_last;

   logic h_wrap;
   logic v_wrap;
   logic h_sync_n_next;
   logic v_sync_n_next;
   logic h_active_next;
   logic v_active_next;

   logic hs_q;
   logic hs_d;
   logic vs_q;
   logic vs_d;
   logic blank_n_q;
   logic blank_n_d;
   logic line_start_q;
   logic line_start_d;
   logic frame_start_q;
   logic frame_start_d;

   // Pixel enable is the last phase of the divider, suppressed while in reset.
   assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
   assign pixel_en = div_last && !Reset;

   always_comb begin
      div_d = div_q + DIV_W'(1);
      if (div_last) begin
         div_d = '0;
      end
   end

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FP      (H_FP),
      .SYNC    (H_SYNC),
      .BP      (H_BP)
   ) u_h_axis (
      .Clk         (Clk),
      .Reset       (Reset),
      .advance     (pixel_en),
      .count       (DrawX),
      .wrap        (h_wrap),
      .sync_n_next (h_sync_n_next),
      .active_next (h_active_next)
   );

   // Vertical axis steps only on a horizontal wrap, so VS edges coincide with DrawX -> 0.
   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FP      (V_FP),
      .SYNC    (V_SYNC),
      .BP      (V_BP)
   ) u_v_axis (
      .Clk         (Clk),
      .Reset       (Reset),
      .advance     (h_wrap),
      .count       (DrawY),
      .wrap        (v_wrap),
      .sync_n_next (v_sync_n_next),
      .active_next (v_active_next)
   );

   always_comb begin
      hs_d          = h_sync_n_next;
      vs_d          = v_sync_n_next;
      blank_n_d     = h_active_next && v_active_next;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         div_q         <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_n_q     <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_n_q     <= blank_n_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: reduced-timing instances at CLK_DIV 2 and 1 plus a default-timing
// instance, each checked every cycle against a raster model through a scoreboard queue.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   typedef struct {
      int unsigned cdiv, hv, hf, hsy, hb, vv, vf, vsy, vb;
   } tp_t;

   typedef struct {
      int unsigned div, x, y;
      logic        ls, fs;
   } ms_t;

   typedef struct {
      int unsigned id;
      logic        pe;
      logic [9:0]  x, y;
      logic        hs, vs, bl, ls, fs;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       pe_s, hs_s, vs_s, bl_s, ls_s, fs_s;
   logic [9:0] dx_s, dy_s;
   logic       pe_c, hs_c, vs_c, bl_c, ls_c, fs_c;
   logic [9:0] dx_c, dy_c;
   logic       pe_d, hs_d, vs_d, bl_d, ls_d, fs_d;
   logic [9:0] dx_d, dy_d;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   tp_t   prm [3];
   ms_t   st  [3];
   string nm  [3];
   exp_t  sb  [$];

   int unsigned cyc, first_pe_s, first_pe_c, last_fs_s, last_fs_c, fs_seen_s, fs_seen_c;
   int unsigned ls_cnt_d, fs_cnt_d, hs_low_d, bl_low_d, vs_low_s, vs_low_c;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .CLK_DIV(2), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut_s (
      .Clk(clk), .Reset(rst), .pixel_en(pe_s), .DrawX(dx_s), .DrawY(dy_s),
      .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(bl_s), .line_start(ls_s), .frame_start(fs_s)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut_c (
      .Clk(clk), .Reset(rst), .pixel_en(pe_c), .DrawX(dx_c), .DrawY(dy_c),
      .VGA_HS(hs_c), .VGA_VS(vs_c), .VGA_BLANK_N(bl_c), .line_start(ls_c), .frame_start(fs_c)
   );

   vga_timing_gen dut_d (
      .Clk(clk), .Reset(rst), .pixel_en(pe_d), .DrawX(dx_d), .DrawY(dy_d),
      .VGA_HS(hs_d), .VGA_VS(vs_d), .VGA_BLANK_N(bl_d), .line_start(ls_d), .frame_start(fs_d)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference raster: a pixel phase that rolls every cdiv cycles, then x, then y.
   function automatic ms_t model_step(input ms_t s, input tp_t p, input logic r);
      ms_t n;
      int unsigned ht, vt;
      ht = p.hv + p.hf + p.hsy + p.hb;
      vt = p.vv + p.vf + p.vsy + p.vb;
      n = s;
      n.ls = 1'b0;
      n.fs = 1'b0;
      if (r) begin
         n.div = 0;
         n.x = 0;
         n.y = 0;
      end else if (s.div + 1 < p.cdiv) begin
         n.div = s.div + 1;
      end else begin
         n.div = 0;
         if (s.x + 1 < ht) begin
            n.x = s.x + 1;
         end else begin
            n.x = 0;
            n.ls = 1'b1;
            if (s.y + 1 < vt) begin
               n.y = s.y + 1;
            end else begin
               n.y = 0;
               n.fs = 1'b1;
            end
         end
      end
      return n;
   endfunction

   function automatic exp_t expect_of(input int unsigned id, input ms_t s, input tp_t p,
                                      input logic r);
      exp_t e;
      int unsigned hss, vss;
      hss = p.hv + p.hf;
      vss = p.vv + p.vf;
      e.id = id;
      e.pe = !r && (s.div == p.cdiv - 1);
      e.x  = 10'(s.x);
      e.y  = 10'(s.y);
      e.hs = !((s.x >= hss) && (s.x < hss + p.hsy));
      e.vs = !((s.y >= vss) && (s.y < vss + p.vsy));
      e.bl = (s.x < p.hv) && (s.y < p.vv);
      e.ls = s.ls;
      e.fs = s.fs;
      return e;
   endfunction

   function automatic exp_t observe(input int unsigned id);
      exp_t o;
      o.id = id;
      case (id)
         0: begin
            o.pe = pe_s; o.x = dx_s; o.y = dy_s; o.hs = hs_s;
            o.vs = vs_s; o.bl = bl_s; o.ls = ls_s; o.fs = fs_s;
         end
         1: begin
            o.pe = pe_c; o.x = dx_c; o.y = dy_c; o.hs = hs_c;
            o.vs = vs_c; o.bl = bl_c; o.ls = ls_c; o.fs = fs_c;
         end
         default: begin
            o.pe = pe_d; o.x = dx_d; o.y = dy_d; o.hs = hs_d;
            o.vs = vs_d; o.bl = bl_d; o.ls = ls_d; o.fs = fs_d;
         end
      endcase
      return o;
   endfunction

   task automatic clear_stats();
      cyc = 0; first_pe_s = 0; first_pe_c = 0; last_fs_s = 0; last_fs_c = 0;
      fs_seen_s = 0; fs_seen_c = 0; ls_cnt_d = 0; fs_cnt_d = 0;
      hs_low_d = 0; bl_low_d = 0; vs_low_s = 0; vs_low_c = 0;
   endtask

   // One clock: advance the model, queue expectations, then compare 1 ns after the edge.
   task automatic tick();
      exp_t e, o;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         st[i] = model_step(st[i], prm[i], rst);
         sb.push_back(expect_of(i, st[i], prm[i], rst));
      end
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.id);
         chk({nm[e.id], ".pixel_en"},    32'(o.pe), 32'(e.pe));
         chk({nm[e.id], ".DrawX"},       32'(o.x),  32'(e.x));
         chk({nm[e.id], ".DrawY"},       32'(o.y),  32'(e.y));
         chk({nm[e.id], ".VGA_HS"},      32'(o.hs), 32'(e.hs));
         chk({nm[e.id], ".VGA_VS"},      32'(o.vs), 32'(e.vs));
         chk({nm[e.id], ".VGA_BLANK_N"}, 32'(o.bl), 32'(e.bl));
         chk({nm[e.id], ".line_start"},  32'(o.ls), 32'(e.ls));
         chk({nm[e.id], ".frame_start"}, 32'(o.fs), 32'(e.fs));
      end
      if (!rst) begin
         cyc++;
         if (pe_s === 1'b1 && first_pe_s == 0) first_pe_s = cyc;
         if (pe_c === 1'b1 && first_pe_c == 0) first_pe_c = cyc;
         if (fs_s === 1'b1) begin
            chk("s.frame_period", cyc - last_fs_s, 750);
            last_fs_s = cyc;
            fs_seen_s++;
         end
         if (fs_c === 1'b1) begin
            chk("c.frame_period", cyc - last_fs_c, 375);
            last_fs_c = cyc;
            fs_seen_c++;
         end
         if (cyc <= 750 && vs_s === 1'b0) vs_low_s++;
         if (cyc <= 375 && vs_c === 1'b0) vs_low_c++;
         if (cyc <= 1600) begin
            if (ls_d === 1'b1) ls_cnt_d++;
            if (fs_d === 1'b1) fs_cnt_d++;
            if (hs_d === 1'b0) hs_low_d++;
            if (bl_d === 1'b0) bl_low_d++;
         end
      end
   endtask

   initial begin
      int unsigned n;
      prm[0] = '{cdiv: 2, hv: 16, hf: 2, hsy: 4, hb: 3, vv: 8, vf: 2, vsy: 2, vb: 3};
      prm[1] = '{cdiv: 1, hv: 16, hf: 2, hsy: 4, hb: 3, vv: 8, vf: 2, vsy: 2, vb: 3};
      prm[2] = '{cdiv: 2, hv: 640, hf: 16, hsy: 96, hb: 48, vv: 480, vf: 10, vsy: 2, vb: 33};
      nm[0] = "s";
      nm[1] = "c";
      nm[2] = "d";
      for (int i = 0; i < 3; i++) st[i] = '{div: 0, x: 0, y: 0, ls: 1'b0, fs: 1'b0};
      clear_stats();

      // Reset held for three cycles.
      rst = 1'b1;
      repeat (3) tick();
      chk("reset.DrawX", 32'(dx_d), 0);
      chk("reset.DrawY", 32'(dy_d), 0);
      chk("reset.hs_vs_blank", {29'd0, hs_d, vs_d, bl_d}, 32'd7);
      chk("reset.pixel_en", 32'(pe_d), 0);
      rst = 1'b0;
      clear_stats();

      // One default-timing line from release.
      repeat (1600) tick();
      chk("d.line_DrawX", 32'(dx_d), 0);
      chk("d.line_DrawY", 32'(dy_d), 1);
      chk("d.line_start_count", ls_cnt_d, 1);
      chk("d.frame_start_count", fs_cnt_d, 0);
      chk("d.hs_low_cycles", hs_low_d, 192);
      chk("d.blank_low_cycles", bl_low_d, 320);
      chk("s.first_pixel_en", first_pe_s, 1);
      chk("c.first_pixel_en", first_pe_c, 1);
      chk("s.vs_low_cycles", vs_low_s, 100);
      chk("c.vs_low_cycles", vs_low_c, 50);
      chk("s.frames_seen", 32'(fs_seen_s >= 2), 1);

      // Reset in the middle of combined horizontal and vertical sync.
      n = 0;
      while (!(st[0].x == 19 && st[0].y == 10) && n < 3000) begin
         tick();
         n++;
      end
      chk("s.reach_sync_point", 32'(st[0].x == 19 && st[0].y == 10), 1);
      chk("s.hs_vs_before_reset", {30'd0, hs_s, vs_s}, 32'd0);
      rst = 1'b1;
      tick();
      chk("s.mid_reset_DrawX", 32'(dx_s), 0);
      chk("s.mid_reset_DrawY", 32'(dy_s), 0);
      chk("s.mid_reset_hs_vs", {30'd0, hs_s, vs_s}, 32'd3);
      chk("s.mid_reset_frame_start", 32'(fs_s), 0);
      chk("s.mid_reset_pixel_en", 32'(pe_s), 0);
      rst = 1'b0;
      clear_stats();

      repeat (800) tick();
      chk("s.frames_after_reset", fs_seen_s, 1);
      chk("c.frames_after_reset", fs_seen_c, 2);
      chk("s.vs_low_after_reset", vs_low_s, 100);
      chk("c.vs_low_after_reset", vs_low_c, 50);
      chk("s.first_pixel_en_after_reset", first_pe_s, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
